nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 140 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Serial adder that adds two W-bit operands one nibble per clock through a
// 4-bit ripple cell, then holds the sum, carry-out and overflow until acknowledged.
module nibble_serial_adder #(
    parameter int NNIB = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              start,
    input  logic              Cin,
    input  logic [4*NNIB-1:0] X,
    input  logic [4*NNIB-1:0] Y,
    output logic              in_ready,
    output logic [4*NNIB-1:0] S,
    output logic              Cout,
    output logic              Ovf,
    output logic              out_valid,
    input  logic              out_ack
);

    localparam int W  = 4 * NNIB;
    localparam int CW = $clog2(NNIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [W-1:0]    x_reg;
    logic [W-1:0]    y_reg;
    logic [W-1:0]    s_reg;
    logic            carry_reg;
    logic [CW-1:0]   cnt_reg;
    logic            cout_reg;
    logic            ovf_reg;

    logic            last_nib;
    logic [CW+1:0]   base;
    logic [3:0]      x_nib;
    logic [3:0]      y_nib;
    logic [3:0]      cell_sum;
    logic [4:0]      rip;

    assign last_nib = (cnt_reg == CW'(NNIB - 1));
    assign base     = {cnt_reg, 2'b00};
    assign x_nib    = x_reg[base +: 4];
    assign y_nib    = y_reg[base +: 4];

    // Ripple cell; rip[3] is the carry into the nibble's top bit, needed for Ovf.
    always_comb begin
        rip      = '0;
        cell_sum = '0;
        rip[0]   = carry_reg;
        for (int i = 0; i < 4; i++) begin
            cell_sum[i] = x_nib[i] ^ y_nib[i] ^ rip[i];
            rip[i+1]    = (x_nib[i] & y_nib[i]) | (rip[i] & (x_nib[i] ^ y_nib[i]));
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            x_reg     <= '0;
            y_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg     <= X;
                        y_reg     <= Y;
                        carry_reg <= Cin;
                        cnt_reg   <= '0;
                        s_reg     <= '0;
                    end
                end
                RUN: begin
                    s_reg[base +: 4] <= cell_sum;
                    carry_reg        <= rip[4];
                    if (last_nib) begin
                        cnt_reg  <= '0;
                        cout_reg <= rip[4];
                        ovf_reg  <= rip[3] ^ rip[4];
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign S    = s_reg;
    assign Cout = cout_reg;
    assign Ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized bench for nibble_serial_adder; results are compared
// against plain integer addition of X + Y + Cin.
module tb_nibble_serial_adder;

    localparam int NNIB = 4;
    localparam int W    = 4 * NNIB;

    logic         Clock;
    logic         Resetn;
    logic         start;
    logic         Cin;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         in_ready;
    logic [W-1:0] S;
    logic         Cout;
    logic         Ovf;
    logic         out_valid;
    logic         out_ack;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.NNIB(NNIB)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .start     (start),
        .Cin       (Cin),
        .X         (X),
        .Y         (Y),
        .in_ready  (in_ready),
        .S         (S),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .out_valid (out_valid),
        .out_ack   (out_ack)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide addition; signed overflow from operand/result signs.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        s    = full[W-1:0];
        co   = full[W];
        ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endtask

    // Called at a negedge; returns after the accepting posedge, at the next negedge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        X = a; Y = b; Cin = c; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check({tag, "_latency"}, n, NNIB);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic c);
        logic [W-1:0] es;
        logic         eco, eov;
        model(a, b, c, es, eco, eov);
        check({tag, "_S"},    {16'd0, S},     {16'd0, es});
        check({tag, "_Cout"}, {31'd0, Cout},  {31'd0, eco});
        check({tag, "_Ovf"},  {31'd0, Ovf},   {31'd0, eov});
        $display("op %s X=%04h Y=%04h Cin=%0d -> S=%04h Cout=%0d Ovf=%0d", tag, a, b, c, S, Cout, Ovf);
    endtask

    task automatic ack_and_hold(input string tag, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic c);
        logic [W-1:0] es;
        logic         eco, eov;
        model(a, b, c, es, eco, eov);
        out_ack = 1'b1;
        @(negedge Clock);
        out_ack = 1'b0;
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_S"},     {16'd0, S}, {16'd0, es});
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic c);
        launch(a, b, c);
        wait_valid(tag);
        check_result(tag, a, b, c);
        ack_and_hold(tag, a, b, c);
    endtask

    initial begin
        logic [W-1:0] ra, rb, s_hold;
        logic         rc;

        Resetn = 1'b0; start = 1'b0; Cin = 1'b0; X = '0; Y = '0; out_ack = 1'b0;
        #1;
        check("rst_S",     {16'd0, S}, 32'd0);
        check("rst_Cout",  {31'd0, Cout}, 32'd0);
        check("rst_Ovf",   {31'd0, Ovf}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        // Start is held high during reset; it must not be taken before release.
        start = 1'b1; X = 16'hAAAA; Y = 16'h5555;
        repeat (2) @(negedge Clock);
        start = 1'b0;
        Resetn = 1'b1;
        @(negedge Clock);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        full_op("basic",  16'h1234, 16'h4321, 1'b0);
        full_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
        full_op("cin",    16'hFFFF, 16'h0000, 1'b1);
        full_op("ovf_p",  16'h7FFF, 16'h0001, 1'b0);
        full_op("ovf_n",  16'h8000, 16'h8000, 1'b0);

        // Busy: start pulses with different operands during RUN and DONE.
        launch(16'h0123, 16'h0456, 1'b1);
        X = 16'hFFFF; Y = 16'hFFFF; Cin = 1'b1; start = 1'b1;
        check("busy_run_ready", {31'd0, in_ready}, 32'd0);
        wait_valid("busy");
        check_result("busy", 16'h0123, 16'h0456, 1'b1);
        s_hold = S;
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            @(negedge Clock);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            check("hold_S",     {16'd0, S}, {16'd0, s_hold});
        end
        start = 1'b0;
        check_result("busy_after_hold", 16'h0123, 16'h0456, 1'b1);
        ack_and_hold("busy", 16'h0123, 16'h0456, 1'b1);

        // Reset after two RUN cycles clears everything immediately.
        launch(16'hFFFF, 16'hFFFF, 1'b1);
        @(posedge Clock);
        @(posedge Clock);
        #2 Resetn = 1'b0;
        #1;
        check("midrst_S",     {16'd0, S}, 32'd0);
        check("midrst_Cout",  {31'd0, Cout}, 32'd0);
        check("midrst_Ovf",   {31'd0, Ovf}, 32'd0);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge Clock);
        Resetn = 1'b1;
        full_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0);
        check("after_rst_val", {16'd0, S}, 32'h1000);

        // Start coincident with the leaving ack is ignored; next cycle is accepted.
        launch(16'h1111, 16'h2222, 1'b0);
        wait_valid("b2b_first");
        check_result("b2b_first", 16'h1111, 16'h2222, 1'b0);
        X = 16'h9999; Y = 16'h8888; Cin = 1'b1; start = 1'b1; out_ack = 1'b1;
        @(negedge Clock);
        out_ack = 1'b0;
        check("b2b_ignored_ready", {31'd0, in_ready}, 32'd1);
        check("b2b_ignored_S", {16'd0, S}, 32'h3333);
        @(negedge Clock);
        start = 1'b0;
        check("b2b_accept_ready", {31'd0, in_ready}, 32'd0);
        wait_valid("b2b_second");
        check_result("b2b_second", 16'h9999, 16'h8888, 1'b1);
        ack_and_hold("b2b_second", 16'h9999, 16'h8888, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            full_op("rand", ra, rb, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
